// File: rtl/spiker_stream_sequencer_if.sv
// Chunk stream link from the spike sequencer to the SNN core.
interface spiker_stream_sequencer_if #(
    parameter int SHIFT_BITS = 4
) ();
    // A beat transfers on a cycle with out_valid_o && out_ready_i; once valid is
    // raised, data/last stay stable until that beat is accepted.
    logic                  out_valid_o;
    logic [SHIFT_BITS-1:0] out_data_o;
    logic                  out_last_o;
    logic                  out_ready_i;

    modport master (
        output out_valid_o,
        output out_data_o,
        output out_last_o,
        input  out_ready_i
    );

    modport slave (
        input  out_valid_o,
        input  out_data_o,
        input  out_last_o,
        output out_ready_i
    );
endinterface

// File: rtl/spiker_stream_sequencer.sv
// Drives the spike shift register and streams its chunks to the SNN core; on
// backpressure it buffers, reloads the register and replays up to the stall point.
module spiker_stream_sequencer #(
    parameter int SHIFT_BITS = 4,
    parameter int N_CHUNKS   = 196,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(N_CHUNKS + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic                  sample_o,
    input  logic [SHIFT_BITS-1:0] chunk_i,
    spiker_stream_sequencer_if.master out_if,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           replay_cnt_o,
    output logic [2:0]            dbg_state_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME  = 3'd1,
        ST_STREAM = 3'd2,
        ST_HOLD   = 3'd3,
        ST_REPLAY = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   pos, pos_n;
    logic [CNT_W-1:0]   skip, skip_n;
    logic               replay_inc;

    logic [SHIFT_BITS:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [FCNT_W-1:0]   fifo_cnt;
    logic                fifo_full, fifo_empty;
    logic                fifo_push, fifo_pop, push_last;

    assign fifo_full  = (fifo_cnt == FCNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_pop   = out_if.out_valid_o && out_if.out_ready_i;

    assign out_if.out_valid_o = !fifo_empty;
    assign out_if.out_data_o  = fifo_empty ? '0 : fifo_mem[rd_ptr][SHIFT_BITS-1:0];
    assign out_if.out_last_o  = fifo_empty ? 1'b0 : fifo_mem[rd_ptr][SHIFT_BITS];

    assign busy_o       = (state != ST_IDLE);
    assign dbg_state_o  = state;

    always_comb begin
        state_n    = state;
        pos_n      = pos;
        skip_n     = skip;
        sample_o   = 1'b0;
        fifo_push  = 1'b0;
        push_last  = 1'b0;
        done_o     = 1'b0;
        replay_inc = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_n = ST_PRIME;
                    pos_n   = '0;
                end
            end
            ST_PRIME: state_n = ST_STREAM;
            ST_STREAM: begin
                if (!fifo_full) begin
                    sample_o  = 1'b1;
                    fifo_push = 1'b1;
                    push_last = (pos == CNT_W'(N_CHUNKS - 1));
                    pos_n     = pos + CNT_W'(1);
                    if (push_last) state_n = ST_DRAIN;
                end else begin
                    // Chunk pos was not taken; the register reloads and must be replayed.
                    state_n = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!fifo_full) begin
                    if (pos == '0) begin
                        state_n = ST_STREAM;
                    end else begin
                        state_n    = ST_REPLAY;
                        skip_n     = '0;
                        replay_inc = 1'b1;
                    end
                end
            end
            ST_REPLAY: begin
                // Shift past chunks 0..pos-1 so chunk pos is presented on entry to STREAM.
                sample_o = 1'b1;
                skip_n   = skip + CNT_W'(1);
                if (skip == pos - CNT_W'(1)) state_n = ST_STREAM;
            end
            ST_DRAIN: begin
                if (fifo_empty || (fifo_cnt == FCNT_W'(1) && fifo_pop)) state_n = ST_DONE;
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        if (abort_i) begin
            state_n   = ST_IDLE;
            fifo_push = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            pos          <= '0;
            skip         <= '0;
            replay_cnt_o <= '0;
        end else begin
            state <= state_n;
            pos   <= pos_n;
            skip  <= skip_n;
            if (replay_inc && replay_cnt_o != 16'hFFFF) replay_cnt_o <= replay_cnt_o + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else if (abort_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) begin
                fifo_mem[wr_ptr] <= {push_last, chunk_i};
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + FCNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - FCNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule
